mem_arbiter: RTL and testbench

- Multi-cycle arbiter sharing one single-port memory between the instruction-fetch path (read-only) and the load/store data path.
- Data requests win by default. A starvation counter guarantees fetch progress.
- Sits between the core's IF/MEM stages and the unified memory. Drives a valid/ready request channel and accepts a separate read-response strobe.

---
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and load/store,
// data wins by default and a starvation counter forces fetch after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_done,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_done,
  output logic                    mem_valid,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;
  state_t                state_q;
  logic [CW-1:0]         starve_q;
  logic                  own_if_q, we_q, valid_q, if_done_q, d_done_q;
  logic [BW-1:0]         be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, if_rdata_q, d_rdata_q;
  logic                  starved, grant_if;
  assign starved  = starve_q == CW'(STARVE_LIMIT);
  assign grant_if = if_req && (!d_req || starved);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      own_if_q   <= 1'b0;
      we_q       <= 1'b0;
      valid_q    <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        IDLE: if (if_req || d_req) begin
          own_if_q <= grant_if;
          we_q     <= grant_if ? 1'b0 : d_we;
          be_q     <= grant_if ? '1 : d_be;
          addr_q   <= grant_if ? if_addr : d_addr;
          wdata_q  <= d_wdata;
          starve_q <= grant_if ? '0 : (if_req && !starved) ? starve_q + 1'b1 : starve_q;
          valid_q  <= 1'b1;
          state_q  <= REQ;
        end
        // only data transactions can be writes, so a write always completes to the data port
        REQ: if (mem_ready) begin
          valid_q  <= 1'b0;
          state_q  <= we_q ? DONE : WAIT_RESP;
          d_done_q <= we_q;
        end
        WAIT_RESP: if (mem_rvalid) begin
          if (own_if_q) if_rdata_q <= mem_rdata;
          else d_rdata_q <= mem_rdata;
          if_done_q <= own_if_q;
          d_done_q  <= !own_if_q;
          state_q   <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign mem_valid = valid_q;
  assign mem_we    = valid_q && we_q;
  assign mem_be    = valid_q ? be_q : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed protocol checks plus a randomized run against a memory/arbitration model.
module tb_mem_arbiter;
  localparam int L = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, if_done, d_req = 1'b0, d_we = 1'b0, d_done;
  logic [31:0] if_addr = '0, if_rdata, d_addr = '0, d_wdata = '0, d_rdata;
  logic [3:0]  d_be = '0, mem_be;
  logic        mem_valid, mem_we, mem_ready = 1'b0, mem_rvalid = 1'b0, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  int          tests = 0, fails = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(L)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  logic [31:0] ref_mem [8];
  logic [31:0] rsp_mem [8];
  logic        rd_pend, stop, exp_if;
  int          rd_idx, rd_dly, nif, nd, n, cnt, cyc;

  initial begin
    repeat (2) tick();
    chk("reset_outs", {if_rdata, if_done, d_rdata, d_done, mem_valid, mem_we, mem_be, mem_addr, mem_wdata, busy}, '0);
    rst = 1'b0;

    // single fetch
    if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1;
    tick();
    chk("fetch_req", {mem_valid, mem_we, mem_be, mem_addr, busy}, {1'b1, 1'b0, 4'hF, 32'h40, 1'b1});
    tick();
    chk("fetch_wait", {if_done, mem_valid}, 2'b00);
    mem_rvalid = 1'b1; mem_rdata = 32'h00A0_0093;
    tick();
    chk("fetch_done", {if_done, d_done, if_rdata}, {1'b1, 1'b0, 32'h00A0_0093});
    if_req = 1'b0; mem_rvalid = 1'b0;
    tick();
    chk("fetch_after", {if_done, busy}, 2'b00);

    // store with backpressure, payload changed after grant
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("st_stable", {mem_valid, mem_we, mem_be, mem_addr, mem_wdata, d_done},
          {1'b1, 1'b1, 4'h3, 32'h100, 32'hDEADBEEF, 1'b0});
      d_addr = 32'h999; d_wdata = 32'h0;
      mem_ready = (i == 4);
    end
    tick();
    chk("st_done", {d_done, if_done, d_rdata, mem_valid, mem_we, mem_be}, {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0});
    d_req = 1'b0;
    tick();
    chk("st_after", {d_done, busy}, 2'b00);

    // spurious rvalid during a write and in idle
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'h55;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; mem_ready = 1'b1;
    tick();
    chk("sp_req", mem_valid, 1'b1);
    tick();
    chk("sp_done", {d_done, if_done, d_rdata, if_rdata}, {1'b1, 1'b0, 32'h0, 32'h00A0_0093});
    d_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sp_idle", {d_done, if_done, busy, d_rdata, if_rdata}, {3'b000, 32'h0, 32'h00A0_0093});
    end
    mem_rvalid = 1'b0;

    // held load request: re-grant only in the IDLE cycle after DONE
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("held_done", d_done, (i % 4 == 3));
      chk("held_busy", busy, (i % 4 != 0));
      chk("held_valid", mem_valid, (i % 4 == 1));
      if (i == 3) chk("held_rdata", d_rdata, 32'hCAFEF00D);
      if (i == 7) d_req = 1'b0;
    end

    // simultaneous requests: starvation pattern
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h400; d_wdata = 32'h1;
    mem_rdata = 32'h0BAD_C0DE;
    cnt = 0; n = 0;
    for (cyc = 0; cyc < 300 && n < 10; cyc++) begin
      tick();
      if (if_done || d_done) begin
        exp_if = (cnt == L);
        cnt = exp_if ? 0 : (cnt + 1 > L ? L : cnt + 1);
        chk("sim_owner", {if_done, d_done}, {exp_if, !exp_if});
        if (exp_if) chk("sim_ifrd", if_rdata, 32'h0BAD_C0DE);
        n++;
        if (n == 10) begin if_req = 1'b0; d_req = 1'b0; end
      end
    end
    chk("sim_count", n, 10);
    mem_rvalid = 1'b0;
    tick();

    // randomized traffic against a reference memory
    for (int k = 0; k < 8; k++) begin ref_mem[k] = $urandom; rsp_mem[k] = ref_mem[k]; end
    rd_pend = 1'b0; rd_idx = 0; rd_dly = 0; nif = 0; nd = 0; stop = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      tick();
      stop = cyc >= 2000;
      if (stop && !if_req && !d_req && !rd_pend && !busy) break;
      chk("r_one_done", if_done && d_done, 1'b0);
      if (if_done) begin
        chk("r_if_held", if_req, 1'b1);
        chk("r_if_rd", if_rdata, ref_mem[if_addr[4:2]]);
        if_req = 1'b0; nif++;
      end
      if (d_done) begin
        chk("r_d_held", d_req, 1'b1);
        if (d_we) ref_mem[d_addr[4:2]] = merge(ref_mem[d_addr[4:2]], d_wdata, d_be);
        else chk("r_d_rd", d_rdata, ref_mem[d_addr[4:2]]);
        d_req = 1'b0; nd++;
      end
      if (!mem_valid) chk("r_idle_we_be", {mem_we, mem_be}, 5'h0);
      if (!if_req && !stop && $urandom_range(3) == 0) begin
        if_req = 1'b1; if_addr = 32'h1000 + 4 * $urandom_range(7);
      end
      if (!d_req && !stop && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_we = $urandom_range(1); d_be = 4'($urandom);
        d_addr = 32'h1000 + 4 * $urandom_range(7); d_wdata = $urandom;
      end
      mem_rvalid = 1'b0;
      if (rd_pend) begin
        if (rd_dly == 0) begin mem_rvalid = 1'b1; mem_rdata = rsp_mem[rd_idx]; rd_pend = 1'b0; end
        else rd_dly--;
      end else begin
        mem_rvalid = 1'($urandom_range(1)); mem_rdata = $urandom;
      end
      mem_ready = $urandom_range(2) != 0;
      if (mem_valid && mem_ready) begin
        chk("r_addr_rng", mem_addr[31:5], 27'(32'h1000 >> 5));
        if (mem_we) rsp_mem[mem_addr[4:2]] = merge(rsp_mem[mem_addr[4:2]], mem_wdata, mem_be);
        else begin rd_pend = 1'b1; rd_idx = int'(mem_addr[4:2]); rd_dly = $urandom_range(2); end
      end
    end
    chk("r_drained", {if_req, d_req, busy}, 3'b000);
    chk("r_progress", (nif > 10) && (nd > 10), 1'b1);

    // reset while waiting for a read response
    mem_rvalid = 1'b0; mem_ready = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
    tick();
    tick();
    chk("rm_wait", {busy, mem_valid}, 2'b10);
    #2 rst = 1'b1;
    #1 chk("rm_async", {if_rdata, if_done, d_rdata, d_done, mem_valid, mem_we, mem_be, mem_addr, mem_wdata, busy}, '0);
    tick();
    rst = 1'b0; d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rm_after", {d_done, if_done, busy, d_rdata}, {3'b000, 32'h0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
